// File: rtl/mem_arbiter_if.sv
// Bundles the two requester ports and the RAM-side strobes and data of the object-RAM arbiter.
// No logic of its own, so it adds no latency.
// Backpressure is a hold-until-ack handshake per requester; the modports only set signal direction.
interface mem_arbiter_if #(
    parameter int ADDR_W   = 7,
    parameter int WORD_W   = 32,
    parameter int STATUS_W = 2
);
    // requester 0: fetch/eval unit
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [WORD_W-1:0] m0_wdata;
    logic              m0_ack;
    logic [WORD_W-1:0] m0_rdata;
    logic              m0_err;

    // requester 1: allocator/GC
    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [WORD_W-1:0] m1_wdata;
    logic              m1_ack;
    logic [WORD_W-1:0] m1_rdata;
    logic              m1_err;

    // single-port object RAM
    logic [ADDR_W-1:0]   ram_addr;
    logic [WORD_W-1:0]   ram_data;
    logic                ram_rden;
    logic                ram_wren;
    logic [WORD_W-1:0]   ram_q;
    logic [STATUS_W-1:0] ram_status;

    logic busy;

    // arbiter side
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  ram_q, ram_status,
        output m0_ack, m0_rdata, m0_err,
        output m1_ack, m1_rdata, m1_err,
        output ram_addr, ram_data, ram_rden, ram_wren,
        output busy
    );

    // requesters and RAM side
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output ram_q, ram_status,
        input  m0_ack, m0_rdata, m0_err,
        input  m1_ack, m1_rdata, m1_err,
        input  ram_addr, ram_data, ram_rden, ram_wren,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single-port object RAM between fetch/eval (m0) and allocator/GC (m1).
// Latency: a request seen in IDLE cycle T is acked in cycle T+3; one access per 4 cycles.
// Backpressure: requesters hold req until their ack; new requests are sampled only in IDLE.
module mem_arbiter #(
    parameter int                  ADDR_W   = 7,
    parameter int                  WORD_W   = 32,   // WORD_SIZE of the core
    parameter int                  STATUS_W = 2,
    parameter logic [STATUS_W-1:0] MEM_OOB  = 1     // status_out code for an out-of-bounds access
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]        state;
    logic              ptr;      // requester that wins the next contested grant
    logic              win;      // requester owning the transaction in flight
    logic              win_we;   // transaction in flight is a write

    logic              pick;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [WORD_W-1:0] sel_wdata;

    // Choose the winner among the requests presented this cycle.
    always_comb begin
        pick = 1'b0;
        if (bus.m0_req && bus.m1_req) begin
            pick = ptr;
        end else begin
            pick = bus.m1_req;
        end
        sel_we    = pick ? bus.m1_we    : bus.m0_we;
        sel_addr  = pick ? bus.m1_addr  : bus.m0_addr;
        sel_wdata = pick ? bus.m1_wdata : bus.m0_wdata;
    end

    // Transaction sequencer; every output is a register updated here.
    // ram_addr/ram_data double as the latched address and write data of the transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= 1'b0;
            win          <= 1'b0;
            win_we       <= 1'b0;
            bus.busy     <= 1'b0;
            bus.ram_addr <= '0;
            bus.ram_data <= '0;
            bus.ram_rden <= 1'b0;
            bus.ram_wren <= 1'b0;
            bus.m0_ack   <= 1'b0;
            bus.m0_rdata <= '0;
            bus.m0_err   <= 1'b0;
            bus.m1_ack   <= 1'b0;
            bus.m1_rdata <= '0;
            bus.m1_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.m0_req || bus.m1_req) begin
                        state        <= ISSUE;
                        bus.busy     <= 1'b1;
                        win          <= pick;
                        win_we       <= sel_we;
                        ptr          <= ~pick;
                        bus.ram_addr <= sel_addr;
                        bus.ram_data <= sel_wdata;
                        bus.ram_rden <= ~sel_we;
                        bus.ram_wren <= sel_we;
                    end
                end
                ISSUE: begin
                    // RAM samples the strobes at this edge; q/status follow one cycle later
                    state        <= WAIT;
                    bus.ram_rden <= 1'b0;
                    bus.ram_wren <= 1'b0;
                end
                WAIT: begin
                    state <= RESP;
                    if (win) begin
                        if (!win_we) begin
                            bus.m1_rdata <= bus.ram_q;
                        end
                        bus.m1_err <= (bus.ram_status == MEM_OOB);
                        bus.m1_ack <= 1'b1;
                    end else begin
                        if (!win_we) begin
                            bus.m0_rdata <= bus.ram_q;
                        end
                        bus.m0_err <= (bus.ram_status == MEM_OOB);
                        bus.m0_ack <= 1'b1;
                    end
                end
                default: begin
                    // RESP: requests are ignored so a held req starts a fresh transaction in IDLE
                    state      <= IDLE;
                    bus.busy   <= 1'b0;
                    bus.m0_ack <= 1'b0;
                    bus.m1_ack <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM, transaction-level reference model and per-cycle compare.
// Directed scenarios followed by randomized traffic with occasional resets and dropped requests.
// Requesters hold req until ack, except for deliberate early drops.
module tb_mem_arbiter;

    localparam int         ADDR_W    = 7;
    localparam int         WORD_W    = 32;
    localparam int         STATUS_W  = 2;
    localparam logic [1:0] ST_OK     = 2'd0;
    localparam logic [1:0] ST_OOB    = 2'd1;
    localparam int         OOB_LIMIT = 120;   // RAM model flags addresses >= this as out of bounds

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .STATUS_W(STATUS_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .STATUS_W(STATUS_W), .MEM_OOB(ST_OOB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int assertions = 0;
    int failures   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WORD_W-1:0] oob_word(input logic [ADDR_W-1:0] a);
        return 32'hBAD0_0000 | 32'(a);
    endfunction

    // ---------------- behavioural RAM (registered q/status) ----------------
    logic [WORD_W-1:0] ram [128];

    always @(posedge clk) begin
        if (bus.ram_rden || bus.ram_wren) begin
            bus.ram_status <= (int'(bus.ram_addr) >= OOB_LIMIT) ? ST_OOB : ST_OK;
            if (bus.ram_rden)
                bus.ram_q <= (int'(bus.ram_addr) >= OOB_LIMIT) ? oob_word(bus.ram_addr) : ram[bus.ram_addr];
            if (bus.ram_wren && int'(bus.ram_addr) < OOB_LIMIT)
                ram[bus.ram_addr] <= bus.ram_data;
        end
    end

    // ---------------- reference model ----------------
    // A grant at edge g means: strobes visible after edge g, ack and new rdata/err after edge g+2,
    // busy after edges g..g+2, and the next grant no earlier than edge g+4.
    int                cyc     = -1;
    int                g       = -100;
    int                free_at = 0;
    bit                ptr     = 1'b0;
    bit                mw, mwe, merr, who;
    logic [ADDR_W-1:0] maddr;
    logic [WORD_W-1:0] mwdata, mrd;
    logic [WORD_W-1:0] shadow [128];
    logic [WORD_W-1:0] last_rd [2];
    bit                last_err [2];

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            g = -100;
            free_at = cyc + 1;
            ptr = 1'b0;
            last_rd[0] = '0;  last_rd[1] = '0;
            last_err[0] = 1'b0; last_err[1] = 1'b0;
        end else begin
            if (cyc == g + 2) begin
                if (!mwe) last_rd[mw] = mrd;
                last_err[mw] = merr;
            end
            if (cyc >= free_at && (bus.m0_req || bus.m1_req)) begin
                who     = (bus.m0_req && bus.m1_req) ? ptr : bus.m1_req;
                ptr     = !who;
                g       = cyc;
                free_at = cyc + 4;
                mw      = who;
                mwe     = who ? bus.m1_we    : bus.m0_we;
                maddr   = who ? bus.m1_addr  : bus.m0_addr;
                mwdata  = who ? bus.m1_wdata : bus.m0_wdata;
                merr    = (int'(maddr) >= OOB_LIMIT);
                if (mwe) begin
                    if (!merr) shadow[maddr] = mwdata;
                end else begin
                    mrd = merr ? oob_word(maddr) : shadow[maddr];
                end
            end
        end
    end

    // Compare every output against the model once per cycle, away from the active edge.
    int d;
    always @(negedge clk) begin
        if (cyc >= 0) begin
            d = cyc - g;
            check("m0_ack",   64'(bus.m0_ack),   64'(d == 2 && !mw));
            check("m1_ack",   64'(bus.m1_ack),   64'(d == 2 && mw));
            check("busy",     64'(bus.busy),     64'(d >= 0 && d <= 2));
            check("ram_rden", 64'(bus.ram_rden), 64'(d == 0 && !mwe));
            check("ram_wren", 64'(bus.ram_wren), 64'(d == 0 && mwe));
            if (d == 0) begin
                check("ram_addr", 64'(bus.ram_addr), 64'(maddr));
                if (mwe) check("ram_data", 64'(bus.ram_data), 64'(mwdata));
            end
            check("m0_rdata", 64'(bus.m0_rdata), 64'(last_rd[0]));
            check("m0_err",   64'(bus.m0_err),   64'(last_err[0]));
            check("m1_rdata", 64'(bus.m1_rdata), 64'(last_rd[1]));
            check("m1_err",   64'(bus.m1_err),   64'(last_err[1]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input bit w, input bit r, input bit we, input logic [ADDR_W-1:0] a,
                           input logic [WORD_W-1:0] dat);
        if (w) begin
            bus.m1_req = r; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = dat;
        end else begin
            bus.m0_req = r; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = dat;
        end
    endtask

    task automatic drop(input bit w);
        if (w) bus.m1_req = 1'b0;
        else   bus.m0_req = 1'b0;
    endtask

    // Issue one transaction from a negedge and wait (bounded) for its ack.
    task automatic do_req(input bit w, input bit we, input logic [ADDR_W-1:0] a,
                          input logic [WORD_W-1:0] dat, output int lat,
                          output logic [WORD_W-1:0] rd, output bit err);
        logic ack;
        set_req(w, 1'b1, we, a, dat);
        lat = 0;
        ack = 1'b0;
        while (!ack && lat < 20) begin
            @(negedge clk);
            lat++;
            ack = w ? bus.m1_ack : bus.m0_ack;
        end
        check("ack_seen", 64'(ack), 64'(1));
        rd  = w ? bus.m1_rdata : bus.m0_rdata;
        err = w ? bus.m1_err   : bus.m0_err;
        drop(w);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- directed and random sequences ----------------
    int                lat, n, k, m0cnt;
    logic [WORD_W-1:0] rd;
    bit                err, seen;
    bit                order [4];
    int                when [4];

    initial begin
        for (int i = 0; i < 128; i++) begin
            ram[i] = '0;
            shadow[i] = '0;
        end
        bus.ram_q = '0;
        bus.ram_status = ST_OK;
        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);

        // reset held two cycles with random requests
        for (int i = 0; i < 2; i++) begin
            set_req(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), $urandom);
            set_req(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), $urandom);
            @(negedge clk);
            check("rst_busy",   64'(bus.busy), 64'(0));
            check("rst_acks",   64'({bus.m0_ack, bus.m1_ack}), 64'(0));
            check("rst_strobe", 64'({bus.ram_rden, bus.ram_wren}), 64'(0));
            check("rst_rdata",  64'(bus.m0_rdata | bus.m1_rdata), 64'(0));
        end
        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
        rst = 1'b0;
        @(negedge clk);

        // m0 write then read back at address 5
        do_req(0, 1'b1, 7'd5, 32'hDEAD, lat, rd, err);
        check("wr_latency", 64'(lat), 64'(3));
        @(negedge clk);
        do_req(0, 1'b0, 7'd5, '0, lat, rd, err);
        check("rd_latency", 64'(lat), 64'(3));
        check("rd_data",    64'(rd),  64'(32'hDEAD));
        check("rd_err",     64'(err), 64'(0));

        // both requesters held from reset: strict alternation, 4-cycle spacing
        set_req(0, 1'b1, 1'b0, 7'd5, '0);
        set_req(1, 1'b1, 1'b0, 7'd6, '0);
        pulse_reset();
        n = 0;
        for (int i = 1; i <= 24 && n < 4; i++) begin
            @(negedge clk);
            if (bus.m0_ack && bus.m1_ack) check("rr_dual_ack", 64'(1), 64'(0));
            if (bus.m0_ack || bus.m1_ack) begin
                order[n] = bus.m1_ack;
                when[n]  = i;
                n++;
            end
        end
        drop(0);
        drop(1);
        check("rr_ack_count", 64'(n), 64'(4));
        if (n == 4) begin
            check("rr_first_lat", 64'(when[0]), 64'(3));
            for (int i = 0; i < 4; i++) check("rr_order", 64'(order[i]), 64'(i % 2));
            for (int i = 1; i < 4; i++) check("rr_spacing", 64'(when[i] - when[i-1]), 64'(4));
        end
        @(negedge clk);

        // out-of-bounds read by m1, then an in-range read clears err
        do_req(1, 1'b0, 7'd127, '0, lat, rd, err);
        check("oob_err",   64'(err), 64'(1));
        check("oob_rdata", 64'(rd),  64'(32'hBAD0_007F));
        @(negedge clk);
        do_req(1, 1'b0, 7'd3, '0, lat, rd, err);
        check("inb_err",   64'(err), 64'(0));
        check("inb_rdata", 64'(rd),  64'(0));
        @(negedge clk);

        // reset during the WAIT cycle of an m0 read aborts it without an ack
        set_req(0, 1'b1, 1'b0, 7'd5, '0);
        @(negedge clk);              // ISSUE
        @(negedge clk);              // WAIT
        rst = 1'b1;
        drop(0);
        @(negedge clk);
        check("abort_ack",  64'(bus.m0_ack), 64'(0));
        check("abort_busy", 64'(bus.busy),   64'(0));
        rst = 1'b0;
        do_req(1, 1'b0, 7'd5, '0, lat, rd, err);
        check("post_rst_lat",   64'(lat), 64'(3));
        check("post_rst_rdata", 64'(rd),  64'(32'hDEAD));
        @(negedge clk);

        // m0 requests continuously; m1 raises once and must not starve
        set_req(0, 1'b1, 1'b0, 7'd5, '0);
        k = $urandom_range(2, 7);
        m0cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (i == k) set_req(1, 1'b1, 1'b0, 7'd9, '0);
            @(negedge clk);
            if (i >= k && bus.m0_ack) m0cnt++;
            if (bus.m1_ack) begin
                seen = 1'b1;
                drop(1);
            end
        end
        check("starve_m1_acked", 64'(seen), 64'(1));
        check("starve_m0_before", 64'(m0cnt < 2), 64'(1));
        drop(0);
        repeat (5) @(negedge clk);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 199) == 0) rst = 1'b1;
            if (bus.m0_ack) drop(0);
            if (bus.m1_ack) drop(1);
            for (int w = 0; w < 2; w++) begin
                if (!(w == 1 ? bus.m1_req : bus.m0_req)) begin
                    if ($urandom_range(0, 2) == 0)
                        set_req(1'(w), 1'b1, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), $urandom);
                end else if ($urandom_range(0, 99) == 0) begin
                    drop(1'(w));   // early drop: transaction still completes
                end
            end
        end
        drop(0);
        drop(1);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
